// File: rtl/btn_debouncer_multi.sv
// Multi-channel button debouncer with hold detection and auto-repeat.
// Each channel has a ce-gated 2-flop synchroniser and a saturating integrator
// that flips the debounced level after 2**COUNTER_WIDTH consecutive
// disagreeing samples. It also emits one-clk click/release pulses.
// Build option: define BTN_DEBOUNCER_MULTI_REPEAT_EN to generate the per-channel
// hold FSM and timers that drive btn_repeat/btn_held. Otherwise both are tied to 0.
module btn_debouncer_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned COUNTER_WIDTH = 16,
  parameter int unsigned HOLD_TICKS    = 50,
  parameter int unsigned REPEAT_TICKS  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] btn_debounced,
  output logic [CHANNELS-1:0] btn_click,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic [CHANNELS-1:0] btn_held
);

  localparam logic [COUNTER_WIDTH-1:0] CntOne = COUNTER_WIDTH'(1);

  if (CHANNELS < 1 || COUNTER_WIDTH < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1)
  begin : gen_param_check
    $error("btn_debouncer_multi: all parameters must be >= 1");
  end

`ifdef BTN_DEBOUNCER_MULTI_REPEAT_EN
  localparam int unsigned MaxTicks   = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned TimerWidth = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;
  localparam logic [TimerWidth-1:0] TimerOne   = TimerWidth'(1);
  localparam logic [TimerWidth-1:0] HoldLast   = TimerWidth'(HOLD_TICKS - 1);
  localparam logic [TimerWidth-1:0] RepeatLast = TimerWidth'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {StReleased, StPressed, StRepeating} hold_state_e;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
    logic                     sync1_q, sync2_q;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     state_q, state_d;
    logic                     flip, rise, fall;
    logic                     click_q, release_q;

    // Integrator: count disagreeing samples, flip on the saturated one.
    always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      flip    = 1'b0;
      if (ce) begin
        if (sync2_q == state_q) begin
          cnt_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          cnt_d   = '0;
          state_d = ~state_q;
          flip    = 1'b1;
        end
      end
    end

    assign rise = flip & ~state_q;
    assign fall = flip & state_q;

    // Synchroniser, integrator and edge pulses; pulses self-clear when ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        cnt_q     <= '0;
        state_q   <= 1'b0;
        click_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if (ce) begin
          sync1_q <= btn[i];
          sync2_q <= sync1_q;
        end
        cnt_q     <= cnt_d;
        state_q   <= state_d;
        click_q   <= rise;
        release_q <= fall;
      end
    end

    assign btn_debounced[i] = state_q;
    assign btn_click[i]     = click_q;
    assign btn_release[i]   = release_q;

`ifdef BTN_DEBOUNCER_MULTI_REPEAT_EN
    hold_state_e           hs_q, hs_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic                  rep, rep_q;

    // Hold FSM: the press tick itself leaves the timer at 0; a release wins
    // over a coinciding repeat.
    always_comb begin
      hs_d    = hs_q;
      timer_d = timer_q;
      rep     = 1'b0;
      if (ce) begin
        case (hs_q)
          StReleased: begin
            if (rise) begin
              hs_d    = StPressed;
              timer_d = '0;
            end
          end
          StPressed: begin
            if (fall) begin
              hs_d = StReleased;
            end else if (timer_q == HoldLast) begin
              hs_d    = StRepeating;
              timer_d = '0;
              rep     = 1'b1;
            end else begin
              timer_d = timer_q + TimerOne;
            end
          end
          StRepeating: begin
            if (fall) begin
              hs_d = StReleased;
            end else if (timer_q == RepeatLast) begin
              timer_d = '0;
              rep     = 1'b1;
            end else begin
              timer_d = timer_q + TimerOne;
            end
          end
          default: begin
            hs_d    = StReleased;
            timer_d = '0;
          end
        endcase
      end
    end

    // Hold state, timer and registered repeat pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hs_q    <= StReleased;
        timer_q <= '0;
        rep_q   <= 1'b0;
      end else begin
        hs_q    <= hs_d;
        timer_q <= timer_d;
        rep_q   <= rep;
      end
    end

    assign btn_repeat[i] = rep_q;
    assign btn_held[i]   = (hs_q == StRepeating);
`endif
  end

`ifndef BTN_DEBOUNCER_MULTI_REPEAT_EN
  assign btn_repeat = '0;
  assign btn_held   = '0;
`endif

endmodule
